addsub16_arbiter: RTL and testbench
===================================

# addsub16_arbiter

- Shares one 16-bit ripple adder/subtractor (one `full_addersub16` instance) between two requesters.
- Arbitrates between two valid/ready request channels, registers the granted operands, and performs one add or subtract.
- Returns the sum, carry-out and signed-overflow flag on the winning requester's response channel.
- Sits between the ALU datapath and its two clients (instruction path and address-generation path) so that only one adder is built.

## Interface

Parameters:
- `WIDTH`, 16, operand/result width; fixed at 16 to match the shared adder instance.

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `req_valid[1:0]`, in, 2, per-requester request valid.
- `req_ready[1:0]`, out, 2, per-requester request accept.
- `req0_a`, `req0_b`, in, 16 each, operands for requester 0.
- `req1_a`, `req1_b`, in, 16 each, operands for requester 1.
- `req_sub[1:0]`, in, 2, per-requester operation: 1 = a−b, 0 = a+b.
- `rsp_valid[1:0]`, out, 2, per-requester response valid.
- `rsp_ready[1:0]`, in, 2, per-requester response accept.
- `rsp_sum`, out, 16, result; shared by both responders and qualified by `rsp_valid`.
- `rsp_cout`, out, 1, adder carry-out. For subtract, 1 = no borrow (a ≥ b unsigned).
- `rsp_ovf`, out, 1, two's-complement overflow.
- `busy`, out, 1, high in any state other than IDLE.

## Operation

- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - The grant is chosen combinationally from `req_valid`.
  - `req_ready[g]` is 1 only for the granted index g, and only while in IDLE.
  - On `req_valid[g] && req_ready[g]`: capture a, b, sub and grant index g, update `last_grant`, then go to EXEC.
- **EXEC**
  - The adder is driven from the captured registers: b XOR {16{sub}}, carry-in = sub.
  - Register `rsp_sum`, `rsp_cout` and `rsp_ovf`, then go to RESP.
  - `rsp_ovf` = (a[15] == b_eff[15]) && (sum[15] != a[15]), where b_eff is the post-XOR operand.
- **RESP**
  - `rsp_valid[g]` = 1; the other `rsp_valid` bit stays 0.
  - Result outputs are held stable until `rsp_ready[g]` is seen; then go to IDLE.
  - `rsp_ready` on the non-granted index is ignored.
- **Arithmetic**: modulo 2^16. `rsp_cout` is bit 16 of the 17-bit sum of a, b_eff and carry-in.
- **Operand stability**: a requester may change or drop its operands after acceptance; the captured copy is used.
- **Requests while busy**:
  - `req_ready` stays 0 for both requesters outside IDLE.
  - Pending requests wait and are neither lost nor duplicated.
- **Simultaneous requests**: resolved by the arbitration policy (see Configuration).
- **Reset (asserted at any time, including mid-operation)**:
  - Any in-flight operation is discarded and no response is issued.
  - State returns to IDLE; `last_grant` resets to 1, so requester 0 wins first.
- **Reset values**:
  - `req_ready` = 2'b01 if `req_valid[0]`, else it follows the combinational grant (0 with no requests).
  - `rsp_valid` = 2'b00, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_ovf` = 0, `busy` = 0.

## Timing

- Accept handshake in cycle T; EXEC in T+1; `rsp_valid` high from T+2.
- Fixed latency from accept to response is 2 cycles.
- With `rsp_ready` held high, the response handshake completes in T+2 and IDLE returns at T+3, where the next accept can occur.
- Peak throughput is therefore one operation per 3 cycles.
- `req_ready` is combinational from state and `req_valid`.
- `rsp_valid`, `rsp_sum`, `rsp_cout` and `rsp_ovf` are registered outputs.
- The adder critical path is confined to the EXEC cycle, from operand registers to result registers.

## Configuration

- Macro: `ADDSUB_ARB_ROUND_ROBIN_EN`.
- **Defined (round-robin)**:
  - When both requesters are valid, the one not equal to `last_grant` wins.
  - A single valid request always wins.
- **Undefined (fixed priority)**: requester 0 always wins when valid; `last_grant` is still updated but unused.

## Test plan

- Reset → all outputs at reset values. Req0 add, a=0x0005, b=0x0001 → accepted at T; `rsp_valid`=2'b01 at T+2; `rsp_sum`=0x0006, `rsp_cout`=0, `rsp_ovf`=0.
- Req1 add, a=0x7475, b=0x5996 → `rsp_valid`=2'b10; `rsp_sum`=0xCE0B, `rsp_cout`=0, `rsp_ovf`=1.
- Req0 add, a=0xF475, b=0xD996 → `rsp_sum`=0xCE0B, `rsp_cout`=1, `rsp_ovf`=0.
- Req0 subtract 0x0005−0x0001 → `rsp_sum`=0x0004, `rsp_cout`=1.
- Req1 subtract 0x0001−0x0005 → `rsp_sum`=0xFFFC, `rsp_cout`=0.
- Both requesters valid continuously, `rsp_ready`=2'b11 → with macro, grants alternate 0,1,0,1 at 3-cycle spacing; without macro, all grants go to 0.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and outputs stable, `req_ready`=0. Assert `rst_n`=0 during EXEC → no response, `busy`=0, and the next request is accepted normally.

Source files
------------

// File: rtl/addsub16_arbiter.sv
// addsub16_arbiter
//   Shares a single 16-bit ripple adder/subtractor between two requesters.
//   A request is arbitrated in IDLE and its operands are captured. The add or
//   subtract runs in EXEC, and the result is presented in RESP on the winning
//   requester's response channel.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]   per-requester request handshake
//   req0_a/b, req1_a/b         operands; req_sub[i] = 1 selects a - b
//   rsp_valid/rsp_ready[1:0]   per-requester response handshake
//   rsp_sum/rsp_cout/rsp_ovf   shared result, qualified by rsp_valid
//   busy                       high whenever the FSM is not in IDLE
//
// Configuration macro
//   ADDSUB_ARB_ROUND_ROBIN_EN  defined   : round-robin between both requesters
//                              undefined : fixed priority, requester 0 first

// Ripple-carry adder. Subtraction inverts b and uses carry-in = sub.
module full_addersub16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf
);
  logic [15:0] b_eff;
  logic [16:0] carry;

  assign b_eff    = b ^ {16{sub}};
  assign carry[0] = sub;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  assign cout = carry[16];
  // Overflow occurs only when the operands have equal signs and the result sign differs.
  assign ovf  = (a[15] == b_eff[15]) && (sum[15] != a[15]);
endmodule

module addsub16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req_sub,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic             grant;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;

  // The adder always sees the captured operands. Its result is only registered
  // in EXEC, so the long carry path runs from operand flops to result flops.
  full_addersub16 u_addsub (
    .a    (a_q),
    .b    (b_q),
    .sub  (sub_q),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // Grant selection. When no request is valid, grant points at requester 1,
  // but req_ready remains 0 because it is also gated by req_valid[grant].
  always_comb begin
    grant = ~req_valid[0];
`ifdef ADDSUB_ARB_ROUND_ROBIN_EN
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end
`endif
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid[grant]) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid[grant]) begin
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          sub_d        = req_sub[grant];
          gnt_d        = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        sum_d              = add_sum;
        cout_d             = add_cout;
        ovf_d              = add_ovf;
        rsp_valid_d        = 2'b00;
        rsp_valid_d[gnt_q] = 1'b1;
        state_d            = RESP;
      end
      RESP: begin
        // Only the granted requester's rsp_ready can release the result.
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rsp_valid_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_addsub16_arbiter.sv
// Testbench for addsub16_arbiter.
//   A negedge monitor keeps an arithmetic model of the block: it tracks the
//   arbitration choice, the pending operation, response timing and the
//   signed/unsigned result. It checks the DUT against this model every cycle.
//   Directed operations also check the DUT against hand-computed literal values.
//   Honours ADDSUB_ARB_ROUND_ROBIN_EN in the same way as the DUT.
module tb_addsub16_arbiter;
  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
  logic        rsp_cout, rsp_ovf, busy;

`ifdef ADDSUB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  // Model state.
  bit          m_pend = 0;
  bit          m_last = 1;
  bit          m_g = 0;
  int          m_acc = 0;
  logic [15:0] m_sum = 0;
  bit          m_cout = 0;
  bit          m_ovf = 0;
  bit          glog[$];
  int          gcyc[$];

  addsub16_arbiter #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d (got no event, expected one)", name, cyc);
  endtask

  function automatic bit pick(input logic [1:0] v, input bit last);
    if (RR && v == 2'b11) return !last;
    return v[0] ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [1:0] ready_fn(input logic [1:0] v, input bit last);
    if (v == 2'b00) return 2'b00;
    return 2'b01 << pick(v, last);
  endfunction

  // Compute the result arithmetically: unsigned for the carry, signed for the overflow.
  task automatic model_op(input logic [15:0] a, input logic [15:0] b, input bit s,
                          output logic [15:0] sum, output bit cout, output bit ovf);
    int ia, ib, sa, sb, r;
    ia   = int'(a);
    ib   = int'(b);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sum  = s ? 16'(ia - ib) : 16'(ia + ib);
    cout = s ? (ia >= ib) : (ia + ib > 65535);
    r    = s ? sa - sb : sa + sb;
    ovf  = (r > 32767) || (r < -32768);
  endtask

  // Per-cycle compare process.
  always @(negedge clk) begin
    logic [1:0] er, ev;
    if (started) begin
      if (!rst_n) begin
        m_pend = 0;
        m_last = 1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'(ready_fn(req_valid, 1'b1)));
      end else begin
        er = m_pend ? 2'b00 : ready_fn(req_valid, m_last);
        ev = (m_pend && cyc >= m_acc + 2) ? (2'b01 << m_g) : 2'b00;
        chk("mon_req_ready", 32'(req_ready), 32'(er));
        chk("mon_busy", 32'(busy), 32'(m_pend));
        chk("mon_rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev != 2'b00) begin
          chk("mon_rsp_sum", 32'(rsp_sum), 32'(m_sum));
          chk("mon_rsp_cout", 32'(rsp_cout), 32'(m_cout));
          chk("mon_rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
        end
        if (!m_pend && er != 2'b00) begin
          m_g = pick(req_valid, m_last);
          if (m_g) model_op(req1_a, req1_b, req_sub[1], m_sum, m_cout, m_ovf);
          else     model_op(req0_a, req0_b, req_sub[0], m_sum, m_cout, m_ovf);
          m_pend = 1;
          m_acc  = cyc;
          m_last = m_g;
          glog.push_back(m_g);
          gcyc.push_back(cyc);
          $display("accept: req%0d at cycle %0d", m_g, cyc);
        end else if (ev != 2'b00 && rsp_ready[m_g]) begin
          m_pend = 0;
          $display("response: req%0d sum=0x%04h cout=%0d ovf=%0d", m_g, rsp_sum, rsp_cout, rsp_ovf);
        end
      end
    end
  end

  task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b, input bit s);
    if (idx == 0) begin req0_a = a; req0_b = b; end
    else          begin req1_a = a; req1_b = b; end
    req_sub[idx] = s;
  endtask

  task automatic wait_accept(input int idx);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready[idx]) seen = 1;
    end
    if (!seen) fail_timeout("accept_wait");
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    // Scramble operands after acceptance; the captured copy must be used.
    set_ops(idx, 16'hA5A5, 16'h5A5A, ~req_sub[idx]);
  endtask

  task automatic wait_rsp(input int idx, output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid[idx]) ok = 1;
    end
    if (!ok) fail_timeout("rsp_wait");
  endtask

  task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b, input bit s,
                       input logic [15:0] es, input bit ec, input bit eo);
    bit ok;
    @(posedge clk);
    #1;
    set_ops(idx, a, b, s);
    req_valid[idx] = 1'b1;
    wait_accept(idx);
    wait_rsp(idx, ok);
    if (ok) begin
      chk("lit_rsp_valid", 32'(rsp_valid), 32'(2'b01 << idx));
      chk("lit_rsp_sum", 32'(rsp_sum), 32'(es));
      chk("lit_rsp_cout", 32'(rsp_cout), 32'(ec));
      chk("lit_rsp_ovf", 32'(rsp_ovf), 32'(eo));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_sub   = 2'b00;
    rsp_ready = 2'b11;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    #2;
    rst_n   = 1'b0;
    started = 1;

    // Reset values, including the combinational req_ready during reset.
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b01;
    @(negedge clk) chk("rst_ready_v01", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk) chk("rst_ready_v11", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk("rst_ready_v00", 32'(req_ready), 32'h0);
    chk("rst_sum_lit", 32'(rsp_sum), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed arithmetic vectors.
    do_op(0, 16'h0005, 16'h0001, 1'b0, 16'h0006, 1'b0, 1'b0);
    do_op(1, 16'h7475, 16'h5996, 1'b0, 16'hCE0B, 1'b0, 1'b1);
    do_op(0, 16'hF475, 16'hD996, 1'b0, 16'hCE0B, 1'b1, 1'b0);
    do_op(0, 16'h0005, 16'h0001, 1'b1, 16'h0004, 1'b1, 1'b0);
    do_op(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(1, 16'h0001, 16'h0005, 1'b1, 16'hFFFC, 1'b0, 1'b0);

    // Both requesters valid continuously; the last grant was requester 1.
    @(posedge clk);
    #1;
    glog.delete();
    gcyc.delete();
    set_ops(0, 16'h0100, 16'h0001, 1'b0);
    set_ops(1, 16'h0200, 16'h0002, 1'b0);
    req_valid = 2'b11;
    repeat (12) @(posedge clk);
    #1 req_valid = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 10);
    chk("both_grant_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      chk("both_grant_order", 32'(glog[i]), RR ? 32'(i % 2) : 32'd0);
    end
    for (int i = 1; i < 4 && i < gcyc.size(); i++) begin
      chk("both_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end

    // Back-pressure: hold rsp_ready low in RESP while requester 1 waits.
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    do_op(0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        set_ops(1, 16'h0010, 16'h0003, 1'b1);
        req_valid[1] = 1'b1;
      end
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      chk("hold_rsp_sum", 32'(rsp_sum), 32'h2345);
      chk("hold_busy", 32'(busy), 32'h1);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b10;
    @(negedge clk) chk("ignore_other_ready", 32'(rsp_valid), 32'h1);
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    wait_accept(1);
    wait_rsp(1, ok);
    if (ok) begin
      chk("pending_rsp_sum", 32'(rsp_sum), 32'h000D);
      chk("pending_rsp_cout", 32'(rsp_cout), 32'h1);
    end

    // Reset asserted during EXEC discards the operation.
    @(posedge clk);
    #1;
    set_ops(0, 16'h1111, 16'h2222, 1'b0);
    req_valid[0] = 1'b1;
    wait_accept(0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstx_busy", 32'(busy), 32'h0);
    chk("rstx_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk) chk("rstx_no_rsp", 32'(rsp_valid), 32'h0);
    end
    do_op(0, 16'h0003, 16'h0004, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
